id_fwd_stage: RTL and testbench
===============================

ID_FWD_STAGE -- requirements
Module: id_fwd_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter FWD_EN, default 1, 1 = EX/MEM forwarding on, 0 = operands always from regfile.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high (RstEnable = 1'b1).
REQ-005 inst_i  in  32  instruction in ID.
REQ-006 stall_i  in  1  downstream hold; ID/EX register keeps its value.
REQ-007 flush_i  in  1  load bubble into ID/EX register.
REQ-008 reg1_data_i / reg2_data_i  in  DATA_W  regfile read data.
REQ-009 reg1_read_o / reg2_read_o  out  1  combinational read enables.
REQ-010 reg1_addr_o / reg2_addr_o  out  5  combinational, always inst_i[25:21] / inst_i[20:16].
REQ-011 ex_wreg_i, ex_wd_i[4:0], ex_wdata_i[DATA_W], ex_is_load_i  in  EX-stage writeback info.
REQ-012 mem_wreg_i, mem_wd_i[4:0], mem_wdata_i[DATA_W]  in  MEM-stage writeback info.
REQ-013 stallreq_o  out  1  combinational load-use stall request.
REQ-014 aluop_o[7:0], alusel_o[2:0], reg1_o/reg2_o[DATA_W], wd_o[4:0], wreg_o, is_load_o, inst_valid_o  out  registered ID/EX outputs.
REQ-015 bubble_cnt_o  out  16  registered count of inserted load-use bubbles.

Function
REQ-016 SHALL decode op=000000 with inst_i[10:6]=0: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011; both reads, wd=inst_i[15:11], wreg=1.
REQ-017 SHALL decode I-type ANDI 001100, ORI 001101, XORI 001110 (zero-extended imm), ADDIU 001001 (sign-extended), LUI 001111 ({imm,16'h0} sign-extended to DATA_W), LW 100011 (sign-extended, is_load=1); reg1 read only, wd=inst_i[20:16], wreg=1.
REQ-018 aluop/alusel SHALL use the EXE_*_OP / EXE_RES_* codes of defines.v (ARITHMETIC for add/sub/slt, LOGIC for and/or/xor/nor/lui, LOAD_STORE for LW).
REQ-019 Any other encoding SHALL load NOP: aluop EXE_NOP_OP, alusel EXE_RES_NOP, wreg=0, inst_valid=0; all-zero word SHALL be a valid NOP with wreg=0.
REQ-020 Operand n with read enable 0 SHALL be imm (reg2 position for I-type), reg1 for LUI is don't-care but SHALL be zero.
REQ-021 Operand with read enable 1, FWD_EN=1: address 0 -> zero; else ex_wreg_i & ex_wd_i match -> ex_wdata_i; else mem match -> mem_wdata_i; else regfile data. EX has priority over MEM.
REQ-022 stallreq_o SHALL be 1 when ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & ex_wd_i equals an enabled read address of a valid decoded instruction; independent of FWD_EN.
REQ-023 Register update priority per edge: stall_i=1 -> hold (counter unchanged); else flush_i=1 -> bubble; else stallreq_o=1 -> bubble and bubble_cnt_o+1; else load decoded values.
REQ-024 Bubble SHALL equal reset values of REQ-026.
REQ-025 bubble_cnt_o SHALL saturate at 16'hFFFF; flush_i SHALL not clear it.

Reset
REQ-026 rst=1 SHALL immediately (no clock) set aluop EXE_NOP_OP, alusel EXE_RES_NOP, reg1_o/reg2_o 0, wd_o NOPRegAddr, wreg_o 0, is_load_o 0, inst_valid_o 0, bubble_cnt_o 0; combinational outputs while rst=1: read enables 0, stallreq_o 0.
REQ-027 Reset asserted mid-stall SHALL discard held contents; first edge after release loads the current instruction normally.

Verification
REQ-028 SUBU $3,$1,$2 (0x00221823), regfile 10/3, no forwarding -> next edge aluop EXE_SUBU_OP, reg1_o 10, reg2_o 3, wd_o 3, wreg_o 1, inst_valid_o 1.
REQ-029 ADDU $4,$1,$1 with ex_wd_i=1 data 7 and mem_wd_i=1 data 9, regfile 5 -> reg1_o=reg2_o=7; with FWD_EN=0 -> 5.
REQ-030 ORI $5,$0,0x8001 with regfile $0 garbage -> reg1_o 0, reg2_o 0x00008001; ADDIU same imm -> reg2_o 0xFFFF8001 (DATA_W=32).
REQ-031 LW in EX writing $2, ID SUBU reading $2 -> stallreq_o 1, next edge bubble (wreg_o 0), bubble_cnt_o 1; same case with stall_i=1 -> outputs and count held.
REQ-032 Undefined op 0x3F and SUBU with sa!=0 -> inst_valid_o 0, wreg_o 0; rst pulse between clock edges -> all outputs reset values without a clock edge.

Source files
------------

// File: rtl/id_fwd_stage.sv
// ============================================================================
//  Module   : id_fwd_stage
//  Purpose  : MIPS-subset ID stage with EX/MEM operand forwarding, load-use
//             stall detection and the ID/EX pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_fwd_stage #(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [4:0]        reg1_addr_o,
  output logic [4:0]        reg2_addr_o,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [4:0]        mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              stallreq_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic              is_load_o,
  output logic              inst_valid_o,
  output logic [15:0]       bubble_cnt_o
);

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  typedef struct packed {
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [4:0]        wd;
    logic              wreg;
    logic              is_load;
    logic              inst_valid;
  } idex_t;

  // NOP opcodes, NOP result select and NOPRegAddr are all zero.
  localparam idex_t IDEX_BUBBLE = '0;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_rd1, dec_rd2, dec_wreg, dec_load, dec_valid, r_ok;
  logic [4:0]        dec_wd;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_aluop  = EXE_NOP_OP;
    dec_alusel = EXE_RES_NOP;
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_wd     = 5'd0;
    dec_wreg   = 1'b0;
    dec_load   = 1'b0;
    dec_valid  = 1'b0;
    dec_imm    = '0;
    r_ok       = 1'b1;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: begin dec_aluop = EXE_ADD_OP;  dec_alusel = EXE_RES_ARITHMETIC; end
          6'b100001: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          6'b100010: begin dec_aluop = EXE_SUB_OP;  dec_alusel = EXE_RES_ARITHMETIC; end
          6'b100011: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          6'b100100: begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC;      end
          6'b100101: begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC;      end
          6'b100110: begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
          6'b100111: begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
          6'b101010: begin dec_aluop = EXE_SLT_OP;  dec_alusel = EXE_RES_ARITHMETIC; end
          6'b101011: begin dec_aluop = EXE_SLTU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          default:   r_ok = 1'b0;
        endcase
        if (r_ok && sa == 5'd0) begin
          dec_rd1   = 1'b1;
          dec_rd2   = 1'b1;
          dec_wd    = rd;
          dec_wreg  = 1'b1;
          dec_valid = 1'b1;
        end else begin
          dec_aluop  = EXE_NOP_OP;
          dec_alusel = EXE_RES_NOP;
        end
      end
      6'b001100: begin dec_aluop = EXE_ANDI_OP;  dec_alusel = EXE_RES_LOGIC;      dec_imm = DATA_W'(imm); end
      6'b001101: begin dec_aluop = EXE_ORI_OP;   dec_alusel = EXE_RES_LOGIC;      dec_imm = DATA_W'(imm); end
      6'b001110: begin dec_aluop = EXE_XORI_OP;  dec_alusel = EXE_RES_LOGIC;      dec_imm = DATA_W'(imm); end
      6'b001001: begin dec_aluop = EXE_ADDIU_OP; dec_alusel = EXE_RES_ARITHMETIC; dec_imm = DATA_W'($signed(imm)); end
      6'b001111: begin dec_aluop = EXE_LUI_OP;   dec_alusel = EXE_RES_LOGIC;      dec_imm = DATA_W'($signed({imm, 16'h0000})); end
      6'b100011: begin dec_aluop = EXE_LW_OP;    dec_alusel = EXE_RES_LOAD_STORE; dec_imm = DATA_W'($signed(imm)); dec_load = 1'b1; end
      default:   r_ok = 1'b0;
    endcase
    if (op != 6'b000000 && r_ok) begin
      dec_rd1   = (op != 6'b001111);
      dec_wd    = rt;
      dec_wreg  = 1'b1;
      dec_valid = 1'b1;
    end
    // The all-zero word is the canonical NOP: valid but writes nothing.
    if (inst_i == 32'h0000_0000) dec_valid = 1'b1;
  end

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              en,
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] immv,
    input logic              exw,
    input logic [4:0]        exd,
    input logic [DATA_W-1:0] exv,
    input logic              memw,
    input logic [4:0]        memd,
    input logic [DATA_W-1:0] memv
  );
    if (!en)                          return immv;
    if (!FWD_EN)                      return rf;
    if (addr == 5'd0)                 return '0;
    if (exw && exd == addr)           return exv;
    if (memw && memd == addr)         return memv;
    return rf;
  endfunction

  logic              stallreq;
  logic [DATA_W-1:0] opnd1, opnd2;

  assign opnd1 = pick_operand(dec_rd1, rs, reg1_data_i, '0, ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign opnd2 = pick_operand(dec_rd2, rt, reg2_data_i, dec_imm, ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign stallreq = !rst && dec_valid && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                    ((dec_rd1 && ex_wd_i == rs) || (dec_rd2 && ex_wd_i == rt));

  assign reg1_read_o = !rst && dec_rd1;
  assign reg2_read_o = !rst && dec_rd2;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;
  assign stallreq_o  = stallreq;

  idex_t       idex_q, idex_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (!stall_i) begin
      if (flush_i) begin
        idex_d = IDEX_BUBBLE;
      end else if (stallreq) begin
        idex_d = IDEX_BUBBLE;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else begin
        idex_d = '{aluop: dec_aluop, alusel: dec_alusel, reg1: opnd1, reg2: opnd2,
                   wd: dec_wd, wreg: dec_wreg, is_load: dec_load, inst_valid: dec_valid};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= IDEX_BUBBLE;
      cnt_q  <= 16'd0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign aluop_o      = idex_q.aluop;
  assign alusel_o     = idex_q.alusel;
  assign reg1_o       = idex_q.reg1;
  assign reg2_o       = idex_q.reg2;
  assign wd_o         = idex_q.wd;
  assign wreg_o       = idex_q.wreg;
  assign is_load_o    = idex_q.is_load;
  assign inst_valid_o = idex_q.inst_valid;
  assign bubble_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_fwd_stage.sv
// ============================================================================
//  Module   : tb_id_fwd_stage
//  Purpose  : Randomised and directed checks of id_fwd_stage against a
//             mnemonic-level reference model; FWD_EN=1 and FWD_EN=0 copies.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_fwd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        stall, flush;
  logic [31:0] rf1, rf2;
  logic        ex_wreg, ex_load, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;

  logic        a_rd1, a_rd2, a_sreq, a_wreg, a_load, a_valid;
  logic [4:0]  a_ad1, a_ad2, a_wd;
  logic [7:0]  a_aluop;
  logic [2:0]  a_alusel;
  logic [31:0] a_r1, a_r2;
  logic [15:0] a_cnt;
  logic        b_rd1, b_rd2, b_sreq, b_wreg, b_load, b_valid;
  logic [4:0]  b_ad1, b_ad2, b_wd;
  logic [7:0]  b_aluop;
  logic [2:0]  b_alusel;
  logic [31:0] b_r1, b_r2;
  logic [15:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_fwd_stage #(.DATA_W(32), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .inst_i(inst), .stall_i(stall), .flush_i(flush),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .reg1_read_o(a_rd1), .reg2_read_o(a_rd2), .reg1_addr_o(a_ad1), .reg2_addr_o(a_ad2),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .stallreq_o(a_sreq), .aluop_o(a_aluop), .alusel_o(a_alusel), .reg1_o(a_r1), .reg2_o(a_r2),
    .wd_o(a_wd), .wreg_o(a_wreg), .is_load_o(a_load), .inst_valid_o(a_valid), .bubble_cnt_o(a_cnt)
  );

  id_fwd_stage #(.DATA_W(32), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .inst_i(inst), .stall_i(stall), .flush_i(flush),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .reg1_read_o(b_rd1), .reg2_read_o(b_rd2), .reg1_addr_o(b_ad1), .reg2_addr_o(b_ad2),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .stallreq_o(b_sreq), .aluop_o(b_aluop), .alusel_o(b_alusel), .reg1_o(b_r1), .reg2_o(b_r2),
    .wd_o(b_wd), .wreg_o(b_wreg), .is_load_o(b_load), .inst_valid_o(b_valid), .bubble_cnt_o(b_cnt)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg, load, valid;
  } idex_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        rd1, rd2;
    logic [4:0]  wd;
    logic        wreg, load, valid;
    logic [31:0] imm;
  } dec_t;

  idex_t       ea, eb;
  logic [15:0] ecnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // R-type ALU op code is the funct field zero-extended to 8 bits.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [15:0] im;
    d  = '0;
    im = w[15:0];
    if (w == 32'h0) begin
      d.valid = 1'b1;
      return d;
    end
    if (w[31:26] == 6'h00) begin
      if (w[10:6] == 5'd0 && w[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B,
                                             6'h24, 6'h25, 6'h26, 6'h27}) begin
        d.aluop  = {2'b00, w[5:0]};
        d.alusel = (w[5:0] inside {6'h24, 6'h25, 6'h26, 6'h27}) ? 3'b001 : 3'b100;
        d.rd1 = 1'b1; d.rd2 = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.valid = 1'b1;
      end
      return d;
    end
    d.rd1 = 1'b1; d.wd = w[20:16]; d.wreg = 1'b1; d.valid = 1'b1;
    case (w[31:26])
      6'h0C: begin d.aluop = 8'h59; d.alusel = 3'b001; d.imm = {16'h0, im}; end
      6'h0D: begin d.aluop = 8'h5A; d.alusel = 3'b001; d.imm = {16'h0, im}; end
      6'h0E: begin d.aluop = 8'h5B; d.alusel = 3'b001; d.imm = {16'h0, im}; end
      6'h09: begin d.aluop = 8'h56; d.alusel = 3'b100; d.imm = {{16{im[15]}}, im}; end
      6'h0F: begin d.aluop = 8'h5C; d.alusel = 3'b001; d.imm = {im, 16'h0}; d.rd1 = 1'b0; end
      6'h23: begin d.aluop = 8'hE3; d.alusel = 3'b111; d.imm = {{16{im[15]}}, im}; d.load = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_opnd(input bit fwd, input logic en, input logic [4:0] a,
                                           input logic [31:0] rf, input logic [31:0] immv);
    if (!en)                      return immv;
    if (!fwd)                     return rf;
    if (a == 0)                   return 32'h0;
    if (ex_wreg && ex_wd == a)    return ex_wdata;
    if (mem_wreg && mem_wd == a)  return mem_wdata;
    return rf;
  endfunction

  task automatic check_regs(input string pfx);
    chk({pfx, "_ctl_a"}, {a_aluop, a_alusel, a_wd, a_wreg, a_load, a_valid},
        {ea.aluop, ea.alusel, ea.wd, ea.wreg, ea.load, ea.valid});
    chk({pfx, "_reg1_a"}, a_r1, ea.r1);
    chk({pfx, "_reg2_a"}, a_r2, ea.r2);
    chk({pfx, "_ctl_b"}, {b_aluop, b_alusel, b_wd, b_wreg, b_load, b_valid},
        {eb.aluop, eb.alusel, eb.wd, eb.wreg, eb.load, eb.valid});
    chk({pfx, "_reg1_b"}, b_r1, eb.r1);
    chk({pfx, "_reg2_b"}, b_r2, eb.r2);
    chk({pfx, "_cnt"}, {a_cnt, b_cnt}, {ecnt, ecnt});
  endtask

  // Inputs are set before the call (mid low phase); checks comb outputs,
  // advances the model across one rising edge and checks the registers.
  task automatic do_cycle(input string pfx);
    dec_t  d;
    logic  sreq;
    idex_t na, nb;
    #1;
    d = ref_decode(inst);
    sreq = ex_load && ex_wreg && ex_wd != 0 && d.valid &&
           ((d.rd1 && ex_wd == inst[25:21]) || (d.rd2 && ex_wd == inst[20:16]));
    chk({pfx, "_addr"}, {a_ad1, a_ad2, b_ad1, b_ad2},
        {inst[25:21], inst[20:16], inst[25:21], inst[20:16]});
    chk({pfx, "_rden"}, {a_rd1, a_rd2, b_rd1, b_rd2}, {d.rd1, d.rd2, d.rd1, d.rd2});
    chk({pfx, "_stallreq"}, {a_sreq, b_sreq}, {sreq, sreq});
    na = '{aluop: d.aluop, alusel: d.alusel, wd: d.wd, wreg: d.wreg, load: d.load, valid: d.valid,
           r1: ref_opnd(1'b1, d.rd1, inst[25:21], rf1, 32'h0),
           r2: ref_opnd(1'b1, d.rd2, inst[20:16], rf2, d.imm)};
    nb = na;
    nb.r1 = ref_opnd(1'b0, d.rd1, inst[25:21], rf1, 32'h0);
    nb.r2 = ref_opnd(1'b0, d.rd2, inst[20:16], rf2, d.imm);
    if (!stall) begin
      if (flush) begin
        ea = '0; eb = '0;
      end else if (sreq) begin
        ea = '0; eb = '0;
        if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
      end else begin
        ea = na; eb = nb;
      end
    end
    @(posedge clk);
    #1;
    check_regs(pfx);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fl [10];
    logic [5:0] il [6];
    logic [4:0] rs, rt, rd;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    il = '{6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h0F, 6'h23};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'd0, fl[$urandom_range(0, 9)]};
      4:          return {6'h00, rs, rt, rd, 5'($urandom_range(1, 31)), fl[$urandom_range(0, 9)]};
      5, 6, 7:    return {il[$urandom_range(0, 5)], rs, rt, 16'($urandom)};
      8:          return $urandom;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic set_quiet();
    stall = 0; flush = 0; ex_wreg = 0; ex_load = 0; ex_wd = 0; ex_wdata = 0;
    mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
  endtask

  initial begin
    rst = 1'b1; inst = 32'h0; rf1 = 0; rf2 = 0;
    set_quiet();
    ea = '0; eb = '0; ecnt = 0;
    #2;
    check_regs("reset");
    chk("reset_comb", {a_rd1, a_rd2, a_sreq}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // SUBU $3,$1,$2 with no forwarding sources
    inst = 32'h0022_1823; rf1 = 10; rf2 = 3;
    do_cycle("subu");
    chk("subu_exact", {a_aluop, a_r1, a_r2, a_wd, a_wreg, a_valid},
        {8'h23, 32'd10, 32'd3, 5'd3, 1'b1, 1'b1});

    // ADDU $4,$1,$1: EX beats MEM; no-forward copy sees regfile
    inst = 32'h0021_2021; rf1 = 5; rf2 = 5;
    ex_wreg = 1; ex_wd = 1; ex_wdata = 7; mem_wreg = 1; mem_wd = 1; mem_wdata = 9;
    do_cycle("addu_fwd");
    chk("addu_fwd_exact", {a_r1, a_r2, b_r1, b_r2}, {32'd7, 32'd7, 32'd5, 32'd5});
    ex_wreg = 0;
    do_cycle("addu_mem");
    chk("addu_mem_exact", {a_r1, a_r2}, {32'd9, 32'd9});
    set_quiet();

    // ORI / ADDIU with garbage on $0
    inst = 32'h3405_8001; rf1 = 32'hDEAD_BEEF; rf2 = 32'hCAFE_F00D;
    do_cycle("ori");
    chk("ori_exact", {a_r1, a_r2}, {32'h0, 32'h0000_8001});
    inst = 32'h2405_8001;
    do_cycle("addiu");
    chk("addiu_exact", a_r2, 32'hFFFF_8001);

    // load-use hazard, then the same with downstream hold
    inst = 32'h0022_1823; ex_load = 1; ex_wreg = 1; ex_wd = 2; ex_wdata = 32'h55;
    do_cycle("lu");
    chk("lu_exact", {a_wreg, a_cnt}, {1'b0, 16'd1});
    stall = 1;
    do_cycle("lu_hold");
    chk("lu_hold_exact", {a_wreg, a_cnt}, {1'b0, 16'd1});
    set_quiet();

    inst = 32'hFC00_0000;
    do_cycle("undef");
    chk("undef_exact", {a_valid, a_wreg}, 2'b00);
    inst = 32'h0022_18E3;
    do_cycle("subu_sa");
    chk("subu_sa_exact", {a_valid, a_wreg}, 2'b00);

    for (int i = 0; i < 1500; i++) begin
      inst = rand_inst();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      rf1 = $urandom; rf2 = $urandom;
      ex_wreg = 1'($urandom); ex_load = 1'($urandom); ex_wd = 5'($urandom_range(0, 7));
      ex_wdata = $urandom;
      mem_wreg = 1'($urandom); mem_wd = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
      do_cycle("rand");
    end

    // asynchronous reset pulse between edges with a hazard present
    set_quiet();
    inst = 32'h0022_1823; rf1 = 1; rf2 = 2;
    do_cycle("pre_rst");
    #2 rst = 1'b1; ex_load = 1; ex_wreg = 1; ex_wd = 2;
    #1;
    ea = '0; eb = '0; ecnt = 0;
    check_regs("rst_pulse");
    chk("rst_pulse_comb", {a_rd1, a_rd2, a_sreq, b_sreq}, 4'b0000);
    rst = 1'b0;
    set_quiet();
    @(negedge clk);

    // reset while holding: held contents dropped, next edge loads normally
    inst = 32'h3405_1234;
    do_cycle("pre_hold");
    stall = 1; inst = 32'h0022_1823;
    do_cycle("hold");
    rst = 1'b1;
    #1 rst = 1'b0;
    ea = '0; eb = '0; ecnt = 0;
    stall = 0;
    do_cycle("after_rst");
    chk("after_rst_exact", {a_aluop, a_valid}, {8'h23, 1'b1});

    // saturate the bubble counter, then confirm flush leaves it alone
    ex_load = 1; ex_wreg = 1; ex_wd = 1;
    for (int i = 0; i < 65540; i++) do_cycle("sat");
    chk("sat_exact", a_cnt, 16'hFFFF);
    flush = 1;
    do_cycle("flush_sat");
    chk("flush_sat_exact", a_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
